// File: rtl/edge_gen_if.sv
// Control and waveform signals of the edge generator, grouped for port use.
// Master drives the train request and parameters; slave is the generator itself.
interface edge_gen_if #(
    parameter int CNT_WIDTH = 16,
    parameter int NUM_WIDTH = 8
);
    logic                 start_i;
    logic                 abort_i;
    logic [CNT_WIDTH-1:0] high_i;
    logic [CNT_WIDTH-1:0] low_i;
    logic [NUM_WIDTH-1:0] num_i;
    logic                 dat_o;
    logic                 re_o;
    logic                 fe_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output start_i, abort_i, high_i, low_i, num_i,
        input  dat_o, re_o, fe_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, high_i, low_i, num_i,
        output dat_o, re_o, fe_o, busy_o, done_o
    );
endinterface

// File: rtl/edge_gen.sv
// Purpose: programmable pulse-train generator (high/low lengths, pulse count, abort).
// Latency: dat_o/re_o/busy_o rise on the same edge that accepts start_i.
// Backpressure: none; start_i is ignored while busy, abort_i always wins.
module edge_gen #(
    parameter int CNT_WIDTH = 16,
    parameter int NUM_WIDTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    edge_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] hi_len, hi_len_nxt;
    logic [CNT_WIDTH-1:0] lo_len, lo_len_nxt;
    logic [NUM_WIDTH-1:0] rem, rem_nxt;
    logic                 cont, cont_nxt;
    logic                 dat_nxt, re_nxt, fe_nxt, done_nxt, busy_nxt;
    logic                 start_ok;

    assign start_ok = bus.start_i && !bus.abort_i &&
                      (bus.high_i != '0) && (bus.low_i != '0);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_len_nxt = hi_len;
        lo_len_nxt = lo_len;
        rem_nxt    = rem;
        cont_nxt   = cont;
        dat_nxt    = bus.dat_o;
        re_nxt     = 1'b0;
        fe_nxt     = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                dat_nxt = 1'b0;
                if (start_ok) begin
                    state_nxt  = HIGH;
                    cnt_nxt    = bus.high_i;
                    hi_len_nxt = bus.high_i;
                    lo_len_nxt = bus.low_i;
                    rem_nxt    = bus.num_i;
                    cont_nxt   = (bus.num_i == '0);
                    dat_nxt    = 1'b1;
                    re_nxt     = 1'b1;
                end
            end
            HIGH: begin
                if (bus.abort_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    dat_nxt   = 1'b0;
                    fe_nxt    = 1'b1;
                end else if (cnt == CNT_WIDTH'(1)) begin
                    state_nxt = LOW;
                    cnt_nxt   = lo_len;
                    dat_nxt   = 1'b0;
                    fe_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            LOW: begin
                if (bus.abort_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    dat_nxt   = 1'b0;
                end else if (cnt == CNT_WIDTH'(1)) begin
                    // Continuous trains never touch rem, so it cannot wrap.
                    if (cont || (rem != NUM_WIDTH'(1))) begin
                        state_nxt = HIGH;
                        cnt_nxt   = hi_len;
                        dat_nxt   = 1'b1;
                        re_nxt    = 1'b1;
                        if (!cont) begin
                            rem_nxt = rem - 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        rem_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                dat_nxt   = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_len     <= '0;
            lo_len     <= '0;
            rem        <= '0;
            cont       <= 1'b0;
            bus.dat_o  <= 1'b0;
            bus.re_o   <= 1'b0;
            bus.fe_o   <= 1'b0;
            bus.busy_o <= 1'b0;
            bus.done_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hi_len     <= hi_len_nxt;
            lo_len     <= lo_len_nxt;
            rem        <= rem_nxt;
            cont       <= cont_nxt;
            bus.dat_o  <= dat_nxt;
            bus.re_o   <= re_nxt;
            bus.fe_o   <= fe_nxt;
            bus.busy_o <= busy_nxt;
            bus.done_o <= done_nxt;
        end
    end

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen: hand-computed waveforms for fixed, continuous,
// rejected, overlapping, back-to-back and reset-interrupted pulse trains.
module tb_edge_gen;

    logic clk;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    edge_gen_if #(.CNT_WIDTH(16), .NUM_WIDTH(8)) bus ();

    edge_gen #(.CNT_WIDTH(16), .NUM_WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic d, input logic r,
                           input logic f, input logic b, input logic dn);
        chk({tag, ".dat"},  32'(bus.dat_o),  32'(d));
        chk({tag, ".re"},   32'(bus.re_o),   32'(r));
        chk({tag, ".fe"},   32'(bus.fe_o),   32'(f));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(b));
        chk({tag, ".done"}, 32'(bus.done_o), 32'(dn));
    endtask

    task automatic set_in(input logic s, input logic a, input logic [15:0] h,
                          input logic [15:0] l, input logic [7:0] n);
        bus.start_i = s;
        bus.abort_i = a;
        bus.high_i  = h;
        bus.low_i   = l;
        bus.num_i   = n;
    endtask

    initial begin
        logic [9:0] exp_dat;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
        #2;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #21;
        rst = 1'b0;
        tick();
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // high=3 low=2 num=2: two pulses, done at cycle 10
        set_in(1'b1, 1'b0, 16'd3, 16'd2, 8'd2);
        exp_dat = 10'b00111_00111; // bit c = dat in cycle c
        for (int c = 0; c <= 11; c++) begin
            tick();
            if (c == 0) bus.start_i = 1'b0;
            if (c < 10)
                chk_out($sformatf("t1_c%0d", c), exp_dat[c], (c == 0) || (c == 5),
                        (c == 3) || (c == 8), 1'b1, 1'b0);
            else
                chk_out($sformatf("t1_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, c == 10);
        end

        // high=1 low=1 continuous, then abort during a high cycle
        set_in(1'b1, 1'b0, 16'd1, 16'd1, 8'd0);
        for (int c = 0; c <= 20; c++) begin
            tick();
            if (c == 0) bus.start_i = 1'b0;
            chk_out($sformatf("t2_c%0d", c), (c % 2) == 0, (c % 2) == 0,
                    (c % 2) == 1, 1'b1, 1'b0);
        end
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        chk_out("t2_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("t2_after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // zero-length phases are rejected
        set_in(1'b1, 1'b0, 16'd0, 16'd5, 8'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("t3_h0_busy%0d", c), 32'(bus.busy_o), 32'd0);
            chk($sformatf("t3_h0_dat%0d", c),  32'(bus.dat_o),  32'd0);
        end
        set_in(1'b1, 1'b0, 16'd5, 16'd0, 8'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("t3_l0_busy%0d", c), 32'(bus.busy_o), 32'd0);
            chk($sformatf("t3_l0_dat%0d", c),  32'(bus.dat_o),  32'd0);
        end

        // abort beats start in IDLE
        set_in(1'b1, 1'b1, 16'd2, 16'd2, 8'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("t4_both%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // start held during a train with new high=9: timing unchanged
        set_in(1'b1, 1'b0, 16'd2, 16'd3, 8'd1);
        for (int c = 0; c <= 5; c++) begin
            tick();
            if (c == 0) bus.high_i = 16'd9;
            if (c == 4) bus.start_i = 1'b0;
            if (c < 5)
                chk_out($sformatf("t4_hold_c%0d", c), c < 2, c == 0, c == 2, 1'b1, 1'b0);
            else
                chk_out("t4_hold_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        tick();
        chk_out("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back: start in the done cycle
        set_in(1'b1, 1'b0, 16'd2, 16'd2, 8'd1);
        for (int c = 0; c <= 4; c++) begin
            tick();
            if (c == 0) bus.start_i = 1'b0;
        end
        chk_out("t5_done1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk_out("t5_restart", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c < 4)
                chk_out($sformatf("t5_c%0d", c), c < 2, 1'b0, c == 2, 1'b1, 1'b0);
            else
                chk_out("t5_done2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // reset mid-HIGH between clock edges
        set_in(1'b1, 1'b0, 16'd5, 16'd2, 8'd1);
        tick();
        bus.start_i = 1'b0;
        chk_out("t6_start", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("t6_high", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_out($sformatf("t6_after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
